// File: rtl/decode_dispatch_scheduler.sv
// Decode-to-dispatch scheduler: in-order instruction FIFO with one-hot per-unit dispatch
// and CTRL serialisation. Optional flush input enabled by defining DISPATCH_FLUSH_EN.
`ifndef RSV_CAPACITY
`define RSV_CAPACITY 16
`endif

module decode_dispatch_scheduler #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned TAG_W = $clog2(`RSV_CAPACITY)
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   decValid,
   input  logic [TAG_W-1:0]       decTag,
   input  logic [2:0]             decFuncType,
   input  logic                   decHasDest,
   output logic                   fetchStall,
   output logic [3:0]             dispValid,
   output logic [TAG_W-1:0]       dispTag,
   output logic                   dispHasDest,
   input  logic [3:0]             unitReady,
   input  logic                   ctrlResolve,
`ifdef DISPATCH_FLUSH_EN
   input  logic                   flush,
`endif
   output logic                   ctrlPending,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflowErr,
   output logic                   badTypeErr
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [2:0]  FT_CTRL = 3'd3;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [2:0]       func_type;
      logic             has_dest;
   } entry_t;

   typedef enum logic {CTRL_IDLE, CTRL_WAIT} ctrl_state_t;

   entry_t           mem [DEPTH];
   entry_t           head;
   entry_t           dec_entry;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   ctrl_state_t      state;
   ctrl_state_t      state_nxt;
   logic             flush_c;
   logic             head_ok_c;
   logic             type_ok_c;
   logic             full_c;
   logic             pop_c;
   logic             bad_pop_c;
   logic             ctrl_pop_c;
   logic             enq_c;
   logic             drop_c;

`ifdef DISPATCH_FLUSH_EN
   assign flush_c = flush;
`else
   assign flush_c = 1'b0;
`endif

   assign dec_entry   = '{tag: decTag, func_type: decFuncType, has_dest: decHasDest};
   assign head        = mem[rd_ptr];
   assign dispTag     = head.tag;
   assign dispHasDest = head.has_dest;
   assign ctrlPending = (state == CTRL_WAIT);
   assign full_c      = (count == CNT_W'(DEPTH));
   assign fetchStall  = (count >= CNT_W'(DEPTH - 2));

   // Head issue, pop/enqueue decisions and CTRL-serialisation next state.
   // A flush cycle withholds dispValid so no unit sees a handshake whose pop is suppressed.
   always_comb begin
      dispValid  = 4'b0000;
      state_nxt  = state;
      head_ok_c  = (count != '0) && (state == CTRL_IDLE) && !flush_c;
      type_ok_c  = !head.func_type[2];
      bad_pop_c  = head_ok_c && !type_ok_c;
      if (head_ok_c && type_ok_c) begin
         dispValid = 4'b0001 << head.func_type[1:0];
      end
      pop_c      = (|(dispValid & unitReady)) || bad_pop_c;
      ctrl_pop_c = pop_c && (head.func_type == FT_CTRL);
      enq_c      = decValid && !flush_c && (!full_c || pop_c);
      drop_c     = decValid && !flush_c && full_c && !pop_c;
      case (state)
         CTRL_IDLE: if (ctrl_pop_c)  state_nxt = CTRL_WAIT;
         CTRL_WAIT: if (ctrlResolve) state_nxt = CTRL_IDLE;
         default:                    state_nxt = CTRL_IDLE;
      endcase
      if (flush_c) begin
         state_nxt = CTRL_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state <= CTRL_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Pointers, occupancy and sticky error flags; flush keeps the error flags.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         overflowErr <= 1'b0;
         badTypeErr  <= 1'b0;
      end else begin
         if (flush_c) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (pop_c) rd_ptr <= rd_ptr + PTR_W'(1);
            if (enq_c) wr_ptr <= wr_ptr + PTR_W'(1);
            count <= count + CNT_W'(enq_c) - CNT_W'(pop_c);
         end
         if (drop_c)    overflowErr <= 1'b1;
         if (bad_pop_c) badTypeErr  <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rstn && enq_c) begin
         mem[wr_ptr] <= dec_entry;
      end
   end
endmodule

// File: tb/tb_decode_dispatch_scheduler.sv
// Bench for decode_dispatch_scheduler: directed scenarios plus a randomized run checked
// against a queue-based reference model.
module tb_decode_dispatch_scheduler;
   localparam int DEPTH = 8;
   localparam int TAG_W = 4;

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic             decValid = 1'b0;
   logic [TAG_W-1:0] decTag = '0;
   logic [2:0]       decFuncType = '0;
   logic             decHasDest = 1'b0;
   logic [3:0]       unitReady = '0;
   logic             ctrlResolve = 1'b0;
   logic             flush = 1'b0;
   logic             fetchStall;
   logic [3:0]       dispValid;
   logic [TAG_W-1:0] dispTag;
   logic             dispHasDest;
   logic             ctrlPending;
   logic [3:0]       count;
   logic             overflowErr;
   logic             badTypeErr;

   int cmps = 0;
   int errs = 0;

   decode_dispatch_scheduler #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk(clk), .rstn(rstn),
      .decValid(decValid), .decTag(decTag), .decFuncType(decFuncType), .decHasDest(decHasDest),
      .fetchStall(fetchStall), .dispValid(dispValid), .dispTag(dispTag), .dispHasDest(dispHasDest),
      .unitReady(unitReady), .ctrlResolve(ctrlResolve),
`ifdef DISPATCH_FLUSH_EN
      .flush(flush),
`endif
      .ctrlPending(ctrlPending), .count(count),
      .overflowErr(overflowErr), .badTypeErr(badTypeErr)
   );

   always #5 clk = ~clk;

   // Reference model: program-order queue, pending-CTRL bit, sticky flags.
   typedef struct {
      logic [TAG_W-1:0] tag;
      logic [2:0]       ft;
      logic             hd;
   } ent_t;

   ent_t       q[$];
   bit         m_pend;
   bit         m_ovf;
   bit         m_bad;
   logic [3:0] m_disp;
   bit         m_pop;

   function automatic void model_eval();
      m_disp = 4'b0000;
      m_pop  = 1'b0;
      if (q.size() > 0 && !m_pend && !flush) begin
         if (q[0].ft < 3'd4) begin
            m_disp = 4'(1 << q[0].ft);
            m_pop  = (m_disp & unitReady) != 4'b0000;
         end else begin
            m_pop = 1'b1;
         end
      end
   endfunction

   task automatic model_commit();
      int  sz;
      bit  ctrl_pop;
      if (!rstn) begin
         q.delete(); m_pend = 0; m_ovf = 0; m_bad = 0;
         return;
      end
      if (flush) begin
         q.delete(); m_pend = 0;
         return;
      end
      sz = q.size();
      ctrl_pop = 0;
      if (m_pop) begin
         if (q[0].ft >= 3'd4) m_bad = 1;
         if (q[0].ft == 3'd3) ctrl_pop = 1;
         void'(q.pop_front());
      end
      if (ctrl_pop) m_pend = 1;
      else if (ctrlResolve) m_pend = 0;
      if (decValid) begin
         if (sz == DEPTH && !m_pop) m_ovf = 1;
         else q.push_back(ent_t'{decTag, decFuncType, decHasDest});
      end
   endtask

   task automatic tick();
      model_eval();
      @(posedge clk);
      model_commit();
      #1;
   endtask

   task automatic drive(input logic v, input logic [TAG_W-1:0] t, input logic [2:0] ft,
                        input logic [3:0] rdy, input logic res);
      decValid = v; decTag = t; decFuncType = ft; decHasDest = t[0];
      unitReady = rdy; ctrlResolve = res;
   endtask

   task automatic do_reset();
      rstn = 1'b0; flush = 1'b0;
      drive(0, '0, 3'd0, 4'h0, 0);
      tick(); tick();
      rstn = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 9; i++) begin
         drive(1, TAG_W'(i), 3'd7, 4'h0, 0);
         tick();
      end
      // reset wins over a concurrent enqueue, pop and resolve
      rstn = 1'b0;
      drive(1, 4'd2, 3'd0, 4'hF, 1);
      tick();
      rstn = 1'b1;
      drive(0, '0, 3'd0, 4'hF, 0);
      #1;
      if (count !== 4'd0) begin errs++; $display("FAIL reset_count: got %0d want 0", count); end
      cmps++;
      if (dispValid !== 4'b0000) begin errs++; $display("FAIL reset_disp: got %b want 0000", dispValid); end
      cmps++;
      if (fetchStall !== 1'b0) begin errs++; $display("FAIL reset_stall: got %b want 0", fetchStall); end
      cmps++;
      if (ctrlPending !== 1'b0) begin errs++; $display("FAIL reset_pend: got %b want 0", ctrlPending); end
      cmps++;
      if ({overflowErr, badTypeErr} !== 2'b00) begin
         errs++; $display("FAIL reset_errs: got %b%b want 00", overflowErr, badTypeErr);
      end
      cmps++;
      tick();
   endtask

   task automatic test_in_order();
      logic [3:0] want_v [3];
      logic [3:0] want_t [3];
      want_v[0] = 4'b0001; want_v[1] = 4'b0010; want_v[2] = 4'b0100;
      want_t[0] = 4'd3;    want_t[1] = 4'd4;    want_t[2] = 4'd5;
      do_reset();
      drive(1, 4'd3, 3'd0, 4'hF, 0);
      #1;
      if (dispValid !== 4'b0000) begin errs++; $display("FAIL order_empty: got %b want 0000", dispValid); end
      cmps++;
      tick();
      for (int i = 0; i < 3; i++) begin
         if (i == 0) drive(1, 4'd4, 3'd1, 4'hF, 0);
         else if (i == 1) drive(1, 4'd5, 3'd2, 4'hF, 0);
         else drive(0, '0, 3'd0, 4'hF, 0);
         #1;
         if (dispValid !== want_v[i] || dispTag !== want_t[i]) begin
            errs++;
            $display("FAIL order_%0d: got v=%b tag=%0d want v=%b tag=%0d", i, dispValid, dispTag, want_v[i], want_t[i]);
         end
         cmps++;
         tick();
      end
      if (count !== 4'd0) begin errs++; $display("FAIL order_drain: count %0d want 0", count); end
      cmps++;
   endtask

   task automatic test_ctrl_serialise();
      do_reset();
      drive(1, 4'd1, 3'd3, 4'hF, 0);
      tick();
      drive(1, 4'd2, 3'd0, 4'hF, 0);
      #1;
      if (dispValid !== 4'b1000 || dispTag !== 4'd1) begin
         errs++; $display("FAIL ctrl_issue: got v=%b tag=%0d want v=1000 tag=1", dispValid, dispTag);
      end
      cmps++;
      tick();
      for (int k = 1; k <= 5; k++) begin
         drive(0, '0, 3'd0, 4'hF, k == 5);
         #1;
         if (ctrlPending !== 1'b1 || dispValid !== 4'b0000) begin
            errs++; $display("FAIL ctrl_wait_%0d: got pend=%b v=%b want pend=1 v=0000", k, ctrlPending, dispValid);
         end
         cmps++;
         tick();
      end
      drive(0, '0, 3'd0, 4'hF, 0);
      #1;
      if (ctrlPending !== 1'b0 || dispValid !== 4'b0001 || dispTag !== 4'd2) begin
         errs++;
         $display("FAIL ctrl_release: got pend=%b v=%b tag=%0d want pend=0 v=0001 tag=2", ctrlPending, dispValid, dispTag);
      end
      cmps++;
      tick();
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 9; i++) begin
         drive(1, TAG_W'(i), 3'd0, 4'h0, 0);
         #1;
         if (count !== 4'(i) || fetchStall !== (i >= DEPTH - 2)) begin
            errs++; $display("FAIL ovf_fill_%0d: got count=%0d stall=%b want count=%0d stall=%b", i, count, fetchStall, i, i >= DEPTH - 2);
         end
         cmps++;
         tick();
      end
      drive(0, '0, 3'd0, 4'hF, 0);
      #1;
      if (count !== 4'd8 || overflowErr !== 1'b1) begin
         errs++; $display("FAIL ovf_flag: got count=%0d ovf=%b want count=8 ovf=1", count, overflowErr);
      end
      cmps++;
      for (int i = 0; i < DEPTH; i++) begin
         drive(0, '0, 3'd0, 4'hF, 0);
         #1;
         if (dispTag !== TAG_W'(i)) begin errs++; $display("FAIL ovf_drain_%0d: tag %0d want %0d", i, dispTag, i); end
         cmps++;
         tick();
      end
   endtask

   task automatic test_full_enq_pop();
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         drive(1, TAG_W'(i), 3'd0, 4'h0, 0);
         tick();
      end
      drive(1, 4'd9, 3'd0, 4'b0001, 0);
      #1;
      if (count !== 4'd8 || dispTag !== 4'd0) begin
         errs++; $display("FAIL full_pre: got count=%0d tag=%0d want count=8 tag=0", count, dispTag);
      end
      cmps++;
      tick();
      drive(0, '0, 3'd0, 4'hF, 0);
      #1;
      if (count !== 4'd8 || overflowErr !== 1'b0) begin
         errs++; $display("FAIL full_swap: got count=%0d ovf=%b want count=8 ovf=0", count, overflowErr);
      end
      cmps++;
      for (int i = 1; i < DEPTH; i++) begin
         if (dispTag !== TAG_W'(i)) begin errs++; $display("FAIL full_order_%0d: tag %0d want %0d", i, dispTag, i); end
         cmps++;
         tick();
      end
      if (dispTag !== 4'd9 || dispValid !== 4'b0001) begin
         errs++; $display("FAIL full_newtag: got tag=%0d v=%b want tag=9 v=0001", dispTag, dispValid);
      end
      cmps++;
      tick();
   endtask

   task automatic test_bad_type();
      do_reset();
      drive(1, 4'd6, 3'd7, 4'hF, 0);
      tick();
      drive(1, 4'd7, 3'd0, 4'hF, 0);
      #1;
      if (dispValid !== 4'b0000 || badTypeErr !== 1'b0) begin
         errs++; $display("FAIL bad_head: got v=%b bad=%b want v=0000 bad=0", dispValid, badTypeErr);
      end
      cmps++;
      tick();
      drive(0, '0, 3'd0, 4'hF, 0);
      #1;
      if (badTypeErr !== 1'b1 || dispValid !== 4'b0001 || dispTag !== 4'd7 || count !== 4'd1) begin
         errs++;
         $display("FAIL bad_next: got bad=%b v=%b tag=%0d count=%0d want bad=1 v=0001 tag=7 count=1", badTypeErr, dispValid, dispTag, count);
      end
      cmps++;
      tick();
   endtask

`ifdef DISPATCH_FLUSH_EN
   task automatic test_flush();
      do_reset();
      drive(1, 4'd1, 3'd3, 4'hF, 0);
      tick();
      for (int i = 2; i <= 6; i++) begin
         drive(1, TAG_W'(i), 3'd0, 4'hF, 0);
         tick();
      end
      flush = 1'b1;
      drive(1, 4'd7, 3'd0, 4'hF, 0);
      #1;
      if (count !== 4'd5 || ctrlPending !== 1'b1) begin
         errs++; $display("FAIL flush_pre: got count=%0d pend=%b want count=5 pend=1", count, ctrlPending);
      end
      cmps++;
      tick();
      flush = 1'b0;
      drive(0, '0, 3'd0, 4'hF, 0);
      #1;
      if (count !== 4'd0 || ctrlPending !== 1'b0 || dispValid !== 4'b0000) begin
         errs++; $display("FAIL flush_post: got count=%0d pend=%b v=%b want 0 0 0000", count, ctrlPending, dispValid);
      end
      cmps++;
      tick();
   endtask
`endif

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         int phase;
         int r;
         phase = (c / 250) % 4;
         rstn = ($urandom_range(0, 499) != 0);
         decValid = ($urandom_range(0, 99) < ((phase == 1) ? 90 : 60));
         decTag = TAG_W'($urandom);
         r = $urandom_range(0, 19);
         decFuncType = (r < 18) ? 3'(r % 4) : 3'($urandom_range(4, 7));
         decHasDest = 1'($urandom);
         unitReady = (phase == 1) ? (4'($urandom) & 4'($urandom) & 4'($urandom)) : 4'($urandom);
         ctrlResolve = ($urandom_range(0, 3) == 0);
`ifdef DISPATCH_FLUSH_EN
         flush = ($urandom_range(0, 99) == 0);
`endif
         #1;
         model_eval();
         if (dispValid !== m_disp) begin errs++; $display("FAIL rnd_disp c=%0d: got %b want %b", c, dispValid, m_disp); end
         cmps++;
         if (!$onehot0(dispValid)) begin errs++; $display("FAIL rnd_onehot c=%0d: got %b want at most one bit", c, dispValid); end
         cmps++;
         if (q.size() > 0) begin
            if (dispTag !== q[0].tag || dispHasDest !== q[0].hd) begin
               errs++; $display("FAIL rnd_head c=%0d: got tag=%0d hd=%b want tag=%0d hd=%b", c, dispTag, dispHasDest, q[0].tag, q[0].hd);
            end
            cmps++;
         end
         if (count !== 4'(q.size())) begin errs++; $display("FAIL rnd_count c=%0d: got %0d want %0d", c, count, q.size()); end
         cmps++;
         if (fetchStall !== (q.size() >= DEPTH - 2)) begin
            errs++; $display("FAIL rnd_stall c=%0d: got %b want %b", c, fetchStall, q.size() >= DEPTH - 2);
         end
         cmps++;
         if (ctrlPending !== m_pend) begin errs++; $display("FAIL rnd_pend c=%0d: got %b want %b", c, ctrlPending, m_pend); end
         cmps++;
         if (overflowErr !== m_ovf || badTypeErr !== m_bad) begin
            errs++; $display("FAIL rnd_errs c=%0d: got ovf=%b bad=%b want ovf=%b bad=%b", c, overflowErr, badTypeErr, m_ovf, m_bad);
         end
         cmps++;
         tick();
      end
      rstn = 1'b1;
      flush = 1'b0;
      drive(0, '0, 3'd0, 4'h0, 0);
      tick();
   endtask

   initial begin
      test_reset();
      test_in_order();
      test_ctrl_serialise();
      test_overflow();
      test_full_enq_pop();
      test_bad_type();
`ifdef DISPATCH_FLUSH_EN
      test_flush();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
      $finish;
   end
endmodule

// File: doc/decode_dispatch_scheduler.md
DECODE_DISPATCH_SCHEDULER -- requirements
Module: decode_dispatch_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning buffer entries (power of two, >=4).
REQ-002 SHALL have parameter TAG_W, default $clog2(`RSV_CAPACITY), meaning instruction tag width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-004 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port decValid  input  1  decoder output valid (no backpressure on decoder).
REQ-006 SHALL have port decTag  input  TAG_W  tag of decoded instruction.
REQ-007 SHALL have port decFuncType  input  3  FuncUnitType_t of decoded instruction.
REQ-008 SHALL have port decHasDest  input  1  instruction writes a destination.
REQ-009 SHALL have port fetchStall  output  1  stop presenting new instructions to the decoder.
REQ-010 SHALL have port dispValid  output  4  one-hot dispatch request, bit0 INT, bit1 FP, bit2 MEM, bit3 CTRL.
REQ-011 SHALL have port dispTag  output  TAG_W  tag of head entry.
REQ-012 SHALL have port dispHasDest  output  1  hasDest of head entry.
REQ-013 SHALL have port unitReady  input  4  per-unit accept, same bit order as dispValid.
REQ-014 SHALL have port ctrlResolve  input  1  single-cycle pulse, outstanding CTRL instruction resolved.
REQ-015 SHALL have port ctrlPending  output  1  CTRL instruction dispatched and unresolved.
REQ-016 SHALL have port count  output  $clog2(DEPTH)+1  occupied entries.
REQ-017 SHALL have port overflowErr, badTypeErr  output  1 each  sticky error flags.

Function
REQ-018 SHALL store {tag, funcType, hasDest} in an in-order circular FIFO; enqueue every cycle decValid=1.
REQ-019 SHALL make an entry enqueued in cycle N visible at head no earlier than cycle N+1.
REQ-020 SHALL drive dispValid combinationally: bit[funcType] of head when count>0, ctrlPending=0, funcType is INT/FP/MEM/CTRL; else 4'b0000.
REQ-021 SHALL pop head in a cycle where (dispValid & unitReady) != 0; dispTag/dispHasDest held stable until popped.
REQ-022 SHALL pop a head with any other funcType value without asserting dispValid and set badTypeErr.
REQ-023 SHALL set ctrlPending on the cycle after a CTRL pop; SHALL clear it the cycle after ctrlResolve; ctrlResolve with ctrlPending=0 ignored.
REQ-024 SHALL block all dispatch (including non-CTRL) while ctrlPending=1; enqueue continues.
REQ-025 SHALL assert fetchStall combinationally when count >= DEPTH-2 (covers two decoder stages in flight).
REQ-026 SHALL accept enqueue when full only if a pop occurs same cycle; otherwise drop entry and set overflowErr.
REQ-027 SHALL leave count unchanged on simultaneous enqueue and pop; pointers wrap modulo DEPTH.
REQ-028 SHALL never assert more than one dispValid bit.

Reset
REQ-029 SHALL on rstn=0 clear pointers, count=0, ctrlPending=0, overflowErr=0, badTypeErr=0, hence dispValid=0, fetchStall=0.
REQ-030 SHALL give reset priority over enqueue, pop, ctrlResolve and flush in the same cycle; in-flight entries discarded.

Configuration
REQ-031 SHALL, with DISPATCH_FLUSH_EN defined, add input flush (1 bit): on flush=1 clear FIFO, count, ctrlPending next cycle, drop that cycle's enqueue, suppress that cycle's pop; error flags retained.
REQ-032 SHALL, without DISPATCH_FLUSH_EN, omit the flush port; FIFO cleared only by reset.

Verification
REQ-033 SHALL cover: enqueue INT tag3, FP tag4, MEM tag5, all unitReady=1 -> dispValid 0001,0010,0100 on consecutive cycles starting 1 cycle after first enqueue, tags 3,4,5.
REQ-034 SHALL cover: CTRL tag1 then INT tag2, ctrlResolve 5 cycles after CTRL pop -> ctrlPending high 5 cycles, INT tag2 dispatched the cycle after ctrlPending falls.
REQ-035 SHALL cover: DEPTH=8, unitReady=0, 8 enqueues -> fetchStall at count=6, 9th enqueue dropped, overflowErr=1, count=8.
REQ-036 SHALL cover: full FIFO, enqueue and pop same cycle -> count stays 8, no overflowErr, new tag appears after 7 further pops.
REQ-037 SHALL cover: funcType=7 at head -> popped, dispValid=0, badTypeErr=1; next entry dispatched following cycle.
REQ-038 SHALL cover: with DISPATCH_FLUSH_EN, count=5, ctrlPending=1, flush with decValid=1 -> next cycle count=0, ctrlPending=0, dispValid=0.
